gb_apu_pulse_generator: RTL and testbench

- Consumer side of channel 1's sweep output: takes the 11-bit shadow frequency and the overflow/mute flag and produces the pulse waveform bit.
- Contains the frequency timer and the 8-step duty sequencer.
- Sits between the sweep function and the channel's envelope/DAC stage. Channel 2 reuses it with mute tied low.

---
 rtl/gb_apu_pkg.sv | 24 ++
 rtl/gb_apu_frequency_timer.sv | 56 +++++
 rtl/gb_apu_pulse_generator.sv | 82 ++++++++
 tb/tb_gb_apu_pulse_generator.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/gb_apu_pkg.sv
// ----------------------------------------------------------------------------
// gb_apu_pkg : shared types and constants for the APU pulse/frequency blocks
// Revision  : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package gb_apu_pkg;

  typedef logic [10:0] freq_t;
  typedef logic [1:0]  duty_t;

  localparam freq_t FREQ_MAX = 11'd2047;

  // Bit n of each entry is the waveform level at sequencer position n.
  localparam logic [7:0] DUTY_PATTERNS [4] = '{
    8'b0000_0001,
    8'b1000_0001,
    8'b1000_0111,
    8'b0111_1110
  };

endpackage

`default_nettype wire

// File: rtl/gb_apu_frequency_timer.sv
// ----------------------------------------------------------------------------
// gb_apu_frequency_timer : prescaler plus 11-bit up-counter with reload
// Revision  : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module gb_apu_frequency_timer
  import gb_apu_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  logic  run,
  input  freq_t frequency,
  output logic  period_done
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESCALE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] prescaler_q, prescaler_d;
  freq_t         timer_q, timer_d;
  logic          tick;

  always_comb begin
    tick        = run && (prescaler_q == PRESCALE_LAST);
    period_done = tick && (timer_q == FREQ_MAX);
    prescaler_d = prescaler_q;
    timer_d     = timer_q;
    if (load) begin
      prescaler_d = '0;
      timer_d     = frequency;
    end else if (run) begin
      prescaler_d = tick ? '0 : prescaler_q + 1'b1;
      // The reload value is sampled only here, so mid-period writes wait.
      if (tick) begin
        timer_d = (timer_q == FREQ_MAX) ? frequency : timer_q + 11'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prescaler_q <= '0;
      timer_q     <= '0;
    end else begin
      prescaler_q <= prescaler_d;
      timer_q     <= timer_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/gb_apu_pulse_generator.sv
// ----------------------------------------------------------------------------
// gb_apu_pulse_generator : frequency timer, 8-step duty sequencer, wave output
// Revision  : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module gb_apu_pulse_generator
  import gb_apu_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trigger,
  input  logic        mute,
  input  logic [10:0] frequency,
  input  logic [1:0]  duty,
  output logic        wave_out,
  output logic [2:0]  duty_step,
  output logic        step_tick,
  output logic        enabled
);

  logic       enabled_q, enabled_d;
  logic [2:0] duty_step_q, duty_step_d;
  logic       step_tick_q, step_tick_d;
  logic       timer_run;
  logic       period_done;
  logic [7:0] pattern_sel;

  assign timer_run = enabled_q && !trigger && !mute;

  gb_apu_frequency_timer #(
    .PRESCALE (PRESCALE)
  ) u_freq_timer (
    .clk         (clk),
    .reset       (reset),
    .load        (trigger),
    .run         (timer_run),
    .frequency   (frequency),
    .period_done (period_done)
  );

  always_comb begin
    enabled_d   = enabled_q;
    duty_step_d = duty_step_q;
    step_tick_d = 1'b0;
    // Trigger wins over mute; duty_step survives retriggers.
    if (trigger) begin
      enabled_d = 1'b1;
    end else if (mute) begin
      enabled_d = 1'b0;
    end else if (enabled_q && period_done) begin
      duty_step_d = duty_step_q + 3'd1;
      step_tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enabled_q   <= 1'b0;
      duty_step_q <= 3'd0;
      step_tick_q <= 1'b0;
    end else begin
      enabled_q   <= enabled_d;
      duty_step_q <= duty_step_d;
      step_tick_q <= step_tick_d;
    end
  end

  always_comb begin
    pattern_sel = DUTY_PATTERNS[duty];
    wave_out    = enabled_q & pattern_sel[duty_step_q];
  end

  assign duty_step = duty_step_q;
  assign step_tick = step_tick_q;
  assign enabled   = enabled_q;

endmodule

`default_nettype wire

// File: tb/tb_gb_apu_pulse_generator.sv
// ----------------------------------------------------------------------------
// tb_gb_apu_pulse_generator : directed and randomized checks against a
// clocks-remaining reference model of the pulse channel
// Revision  : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_gb_apu_pulse_generator;

  localparam int P = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        trigger;
  logic        mute;
  logic [10:0] frequency;
  logic [1:0]  duty;
  logic        wave_out;
  logic [2:0]  duty_step;
  logic        step_tick;
  logic        enabled;

  gb_apu_pulse_generator #(
    .PRESCALE (P)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .trigger   (trigger),
    .mute      (mute),
    .frequency (frequency),
    .duty      (duty),
    .wave_out  (wave_out),
    .duty_step (duty_step),
    .step_tick (step_tick),
    .enabled   (enabled)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Model: enable flag, step index, and clocks left until the next step.
  int m_en, m_step, m_tick, m_left;

  function automatic int pat(int d, int s);
    logic [7:0] p;
    case (d)
      0:       p = 8'b0000_0001;
      1:       p = 8'b1000_0001;
      2:       p = 8'b1000_0111;
      default: p = 8'b0111_1110;
    endcase
    return int'(p[s]);
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (reset) begin
      m_en = 0; m_step = 0; m_tick = 0; m_left = 0;
    end else if (trigger) begin
      m_en = 1; m_tick = 0; m_left = (2048 - int'(frequency)) * P;
    end else if (mute) begin
      m_en = 0; m_tick = 0;
    end else if (m_en != 0) begin
      m_tick = 0;
      m_left--;
      if (m_left == 0) begin
        m_step = (m_step + 1) % 8;
        m_tick = 1;
        m_left = (2048 - int'(frequency)) * P;
      end
    end else begin
      m_tick = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check("enabled", int'(enabled), m_en);
    check("duty_step", int'(duty_step), m_step);
    check("step_tick", int'(step_tick), m_tick);
    check("wave_out", int'(wave_out), (m_en != 0) ? pat(int'(duty), m_step) : 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_tick(output int n);
    n = 0;
    do begin
      cycle();
      n++;
    end while (!step_tick && n < 20000);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  task automatic do_trigger(input int f);
    frequency = 11'(f);
    trigger   = 1'b1;
    cycle();
    trigger   = 1'b0;
  endtask

  int n;
  int frozen;
  int exp0 [4];
  int exp7 [4];

  initial begin
    reset = 1'b1; trigger = 1'b0; mute = 1'b0; frequency = '0; duty = '0;
    exp0 = '{1, 1, 1, 0};
    exp7 = '{0, 1, 1, 0};

    cycle();
    reset = 1'b0;
    check("rst_enabled", int'(enabled), 0);
    check("rst_step", int'(duty_step), 0);
    check("rst_tick", int'(step_tick), 0);
    check("rst_wave", int'(wave_out), 0);

    // Fastest period.
    duty = 2'd2;
    do_trigger(2047);
    wait_tick(n);
    check("lat_2047_first", n, 4);
    wait_tick(n);
    check("lat_2047_next", n, 4);
    run(30);

    // Mid-period frequency write only affects the next reload.
    do_trigger(2046);
    run(3);
    frequency = 11'd2047;
    wait_tick(n);
    check("lat_2046_rest", n, 5);
    wait_tick(n);
    check("lat_after_write", n, 4);

    // Mute freezes everything until the next trigger.
    do_trigger(2040);
    run(50);
    mute = 1'b1;
    cycle();
    mute = 1'b0;
    check("mute_enabled", int'(enabled), 0);
    check("mute_wave", int'(wave_out), 0);
    frozen = int'(duty_step);
    run(100);
    check("mute_frozen", int'(duty_step), frozen);
    do_trigger(2040);
    check("mute_resume_step", int'(duty_step), frozen);
    wait_tick(n);
    check("resume_lat", n, 32);
    check("resume_step", int'(duty_step), (frozen + 1) % 8);

    // Trigger beats mute; lingering mute then disables.
    mute = 1'b1;
    do_trigger(2047);
    check("trig_mute_en", int'(enabled), 1);
    cycle();
    check("mute_after_trig", int'(enabled), 0);
    mute = 1'b0;

    // Duty sweep at step 0 and step 7.
    do_reset();
    do_trigger(0);
    for (int d = 0; d < 4; d++) begin
      duty = 2'(d);
      #1;
      check("duty_sweep_s0", int'(wave_out), exp0[d]);
    end
    do_trigger(2047);
    for (int i = 0; i < 7; i++) wait_tick(n);
    do_trigger(0);
    check("at_step7", int'(duty_step), 7);
    for (int d = 0; d < 4; d++) begin
      duty = 2'(d);
      #1;
      check("duty_sweep_s7", int'(wave_out), exp7[d]);
    end

    // Reset mid-period at step 5.
    do_reset();
    do_trigger(2047);
    for (int i = 0; i < 5; i++) wait_tick(n);
    do_trigger(2000);
    run(10);
    check("pre_reset_step", int'(duty_step), 5);
    do_reset();
    check("mid_rst_enabled", int'(enabled), 0);
    check("mid_rst_step", int'(duty_step), 0);
    check("mid_rst_wave", int'(wave_out), 0);
    do_trigger(2040);
    wait_tick(n);
    check("post_rst_lat", n, 32);
    check("post_rst_step", int'(duty_step), 1);

    // Randomized traffic.
    for (int i = 0; i < 20000; i++) begin
      reset   = ($urandom_range(0, 1023) == 0);
      trigger = ($urandom_range(0, 99) == 0);
      mute    = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 15) == 0) duty = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 31) == 0) begin
        if ($urandom_range(0, 19) == 0) frequency = 11'($urandom_range(0, 2047));
        else frequency = 11'($urandom_range(2030, 2047));
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
